// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - handshake/status bundle between the FIFO and its producer/consumer
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] din;
  logic              wr;
  logic              rd;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, wr, rd, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  din, wr, rd, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, thresholds and sticky errors
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty, wr_ok, rd_ok;

  // Flags decode the registered count only, so they never depend on same-cycle requests
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A read frees a slot on the same edge, so a full FIFO still takes a write when it is also read
  assign rd_ok = bus.rd & ~empty;
  assign wr_ok = bus.wr & (~full | rd_ok);

  // Next-state for pointers, occupancy, read data and error flags
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = rd_ok;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = mem_q[rptr_q];
    end

    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;

    // Clear first so that a coinciding new error event wins
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr && !wr_ok) overflow_d  = 1'b1;
    if (bus.rd && empty)  underflow_d = 1'b1;
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array is intentionally not reset; writes blocked while reset is held
  always_ff @(posedge clk) begin
    if (wr_ok && rst) mem_q[wptr_q] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign bus.almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [31:0] vals [16] = '{32'd100, 32'd150, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60,
                             32'd70, 32'd80, 32'd90, 32'd110, 32'd120, 32'd130, 32'd140, 32'd160};

  sync_fifo_param_if #(.DATA_W(32), .DEPTH(16)) bus ();

  sync_fifo_param #(.DATA_W(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given requests; returns 1 time unit after the edge
  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic c);
    bus.wr = w; bus.rd = r; bus.din = d; bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.din = '0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %0b want 0", bus.full); else pass_cnt++;
    total_cnt++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else pass_cnt++;
    total_cnt++; if (bus.dout !== 32'd0) $display("FAIL reset_dout: got %0d want 0", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_aempty: got %0b want 1", bus.almost_empty); else pass_cnt++;
    total_cnt++; if (bus.almost_full !== 1'b0) $display("FAIL reset_afull: got %0b want 0", bus.almost_full); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL reset_err: got ovf=%0b unf=%0b want 0 0", bus.overflow, bus.underflow); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_dvalid: got %0b want 0", bus.dout_valid); else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, vals[i], 1'b0);
      total_cnt++; if (bus.count !== 5'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); else pass_cnt++;
      total_cnt++; if (bus.almost_full !== (i + 1 >= 12)) $display("FAIL fill_afull[%0d]: got %0b want %0b", i, bus.almost_full, (i + 1 >= 12)); else pass_cnt++;
      total_cnt++; if (bus.almost_empty !== (i + 1 <= 4)) $display("FAIL fill_aempty[%0d]: got %0b want %0b", i, bus.almost_empty, (i + 1 <= 4)); else pass_cnt++;
      total_cnt++; if (bus.full !== (i == 15)) $display("FAIL fill_full[%0d]: got %0b want %0b", i, bus.full, (i == 15)); else pass_cnt++;
    end
    step(1'b1, 1'b0, 32'd999, 1'b0);
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", bus.overflow); else pass_cnt++;
    total_cnt++; if (bus.count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", bus.count); else pass_cnt++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 32'd0, 1'b0);
      total_cnt++; if (bus.dout !== vals[i]) $display("FAIL drain_dout[%0d]: got %0d want %0d", i, bus.dout, vals[i]); else pass_cnt++;
      total_cnt++; if (bus.dout_valid !== 1'b1) $display("FAIL drain_dvalid[%0d]: got %0b want 1", i, bus.dout_valid); else pass_cnt++;
    end
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL drain_empty: got %0b want 1", bus.empty); else pass_cnt++;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL dvalid_pulse: got %0b want 0", bus.dout_valid); else pass_cnt++;
    step(1'b0, 1'b1, 32'd0, 1'b0);
    total_cnt++; if (bus.underflow !== 1'b1) $display("FAIL unf_flag: got %0b want 1", bus.underflow); else pass_cnt++;
    total_cnt++; if (bus.dout !== 32'd160) $display("FAIL unf_dout_hold: got %0d want 160", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL unf_dvalid: got %0b want 0", bus.dout_valid); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", bus.overflow); else pass_cnt++;
    step(1'b0, 1'b0, 32'd0, 1'b1);
    total_cnt++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL clr_err: got ovf=%0b unf=%0b want 0 0", bus.overflow, bus.underflow); else pass_cnt++;
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, vals[i], 1'b0);
    step(1'b1, 1'b1, 32'd777, 1'b0);
    total_cnt++; if (bus.dout !== 32'd100) $display("FAIL sfull_dout: got %0d want 100", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.count !== 5'd16) $display("FAIL sfull_count: got %0d want 16", bus.count); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b1) $display("FAIL sfull_full: got %0b want 1", bus.full); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL sfull_ovf: got %0b want 0", bus.overflow); else pass_cnt++;
    for (int i = 1; i < 17; i++) begin
      step(1'b0, 1'b1, 32'd0, 1'b0);
      total_cnt++; if (bus.dout !== ((i == 16) ? 32'd777 : vals[i]))
        $display("FAIL sfull_order[%0d]: got %0d want %0d", i, bus.dout, ((i == 16) ? 32'd777 : vals[i])); else pass_cnt++;
    end
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sfull_drained: got %0b want 1", bus.empty); else pass_cnt++;
  endtask

  task automatic test_simul_empty();
    step(1'b1, 1'b1, 32'd55, 1'b0);
    total_cnt++; if (bus.count !== 5'd1) $display("FAIL sempty_count: got %0d want 1", bus.count); else pass_cnt++;
    total_cnt++; if (bus.underflow !== 1'b1) $display("FAIL sempty_unf: got %0b want 1", bus.underflow); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL sempty_dvalid: got %0b want 0", bus.dout_valid); else pass_cnt++;
    total_cnt++; if (bus.dout !== 32'd777) $display("FAIL sempty_no_wt: got %0d want 777", bus.dout); else pass_cnt++;
    step(1'b0, 1'b1, 32'd0, 1'b1);
    total_cnt++; if (bus.dout !== 32'd55) $display("FAIL sempty_read: got %0d want 55", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.underflow !== 1'b0) $display("FAIL sempty_clr: got %0b want 0", bus.underflow); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'(200 + 100 * pass + i), 1'b0);
      total_cnt++; if (bus.count !== 5'd10) $display("FAIL wrap_count_full[%0d]: got %0d want 10", pass, bus.count); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b1, 32'd0, 1'b0);
        total_cnt++; if (bus.dout !== 32'(200 + 100 * pass + i))
          $display("FAIL wrap_dout[%0d][%0d]: got %0d want %0d", pass, i, bus.dout, 200 + 100 * pass + i); else pass_cnt++;
      end
      total_cnt++; if (bus.count !== 5'd0) $display("FAIL wrap_count_empty[%0d]: got %0d want 0", pass, bus.count); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(i + 1), 1'b0);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd6, 1'b0);
    total_cnt++; if (bus.count !== 5'd5) $display("FAIL arst_pre_count: got %0d want 5", bus.count); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (bus.count !== 5'd0) $display("FAIL arst_count: got %0d want 0", bus.count); else pass_cnt++;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL arst_empty: got %0b want 1", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.dout !== 32'd0) $display("FAIL arst_dout: got %0d want 0", bus.dout); else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 1'b0, 32'd42, 1'b0);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    total_cnt++; if (bus.dout !== 32'd42) $display("FAIL arst_reuse: got %0d want 42", bus.dout); else pass_cnt++;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL arst_reuse_empty: got %0b want 1", bus.empty); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_fill();
    test_drain();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
